// File: rtl/load_extend_unit.sv
// Load formatting stage: byte/halfword/word extraction with sign/zero extension,
// unaligned LWL/LWR merge, alignment checking and a one-entry output register.
module load_extend_unit #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ERRCNT_W = 8,
    localparam int unsigned NB      = DATA_W / 8,
    localparam int unsigned OFS_W   = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          mode,
    input  logic [OFS_W-1:0]    byte_ofs,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic [DATA_W-1:0]   rt_old,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   result,
    output logic                err,
    output logic [ERRCNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        MODE_LB   = 3'd0,
        MODE_LBU  = 3'd1,
        MODE_LH   = 3'd2,
        MODE_LHU  = 3'd3,
        MODE_LW   = 3'd4,
        MODE_LWL  = 3'd5,
        MODE_LWR  = 3'd6,
        MODE_RSVD = 3'd7
    } mode_e;

    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                err_q, err_d;
    logic [ERRCNT_W-1:0] err_count_q, err_count_d;

    logic                accept;
    int unsigned         ofs;
    int unsigned         lwl_bytes;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic [DATA_W-1:0]   lo_mask;
    logic [DATA_W-1:0]   hi_mask;
    logic [DATA_W-1:0]   fmt_res;
    logic                fmt_err;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Combinational formatting of the incoming request.
    always_comb begin
        ofs       = 32'(byte_ofs);
        lwl_bytes = (ofs < NB) ? (NB - 1 - ofs) : 0;
        byte_sel  = 8'(mem_rdata >> (8 * ofs));
        half_sel  = 16'(mem_rdata >> (8 * ofs));
        lo_mask   = ~({DATA_W{1'b1}} << (8 * lwl_bytes));
        hi_mask   = ~({DATA_W{1'b1}} >> (8 * ofs));
        fmt_res   = '0;
        fmt_err   = 1'b0;
        case (mode_e'(mode))
            MODE_LB:  fmt_res = DATA_W'($signed(byte_sel));
            MODE_LBU: fmt_res = DATA_W'(byte_sel);
            MODE_LH:  begin
                fmt_res = DATA_W'($signed(half_sel));
                fmt_err = byte_ofs[0];
            end
            MODE_LHU: begin
                fmt_res = DATA_W'(half_sel);
                fmt_err = byte_ofs[0];
            end
            MODE_LW:  begin
                fmt_res = mem_rdata;
                fmt_err = (ofs != 0);
            end
            MODE_LWL: fmt_res = (mem_rdata << (8 * lwl_bytes)) | (rt_old & lo_mask);
            MODE_LWR: fmt_res = (mem_rdata >> (8 * ofs)) | (rt_old & hi_mask);
            default:  fmt_err = 1'b1;
        endcase
        // Offsets past the last byte only exist for non-power-of-two widths.
        if (ofs >= NB) begin
            fmt_err = 1'b1;
        end
        if (fmt_err) begin
            fmt_res = '0;
        end
    end

    // Output register next state: load on accept, drain on consumer handshake.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        err_d       = err_q;
        err_count_d = err_count_q;
        if (accept) begin
            out_valid_d = 1'b1;
            result_d    = fmt_res;
            err_d       = fmt_err;
            if (fmt_err && (err_count_q != {ERRCNT_W{1'b1}})) begin
                err_count_d = err_count_q + ERRCNT_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign err       = err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_load_extend_unit.sv
// Bench for load_extend_unit: directed vectors, throughput/backpressure, counter
// saturation (narrow-counter instance), async reset, then random traffic vs a byte-level model.
module tb_load_extend_unit;

    localparam int unsigned DW = 32;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [2:0]  mode;
    logic [1:0]  byte_ofs;
    logic [31:0] mem_rdata;
    logic [31:0] rt_old;
    logic        out_ready;

    logic        in_ready,  out_valid,  err;
    logic [31:0] result;
    logic [7:0]  err_count;
    logic        in_ready2, out_valid2, err2;
    logic [31:0] result2;
    logic [1:0]  err_count2;

    always #5 clk = ~clk;

    load_extend_unit #(.DATA_W(DW), .ERRCNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .byte_ofs(byte_ofs), .mem_rdata(mem_rdata), .rt_old(rt_old),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .err(err),
        .err_count(err_count)
    );

    load_extend_unit #(.DATA_W(DW), .ERRCNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready2),
        .mode(mode), .byte_ofs(byte_ofs), .mem_rdata(mem_rdata), .rt_old(rt_old),
        .out_valid(out_valid2), .out_ready(out_ready), .result(result2), .err(err2),
        .err_count(err_count2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model of what the output register should hold.
    logic        m_valid;
    logic [31:0] m_res;
    logic        m_err;
    int          m_cnt;
    int          m_cnt2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Load semantics expressed on individual bytes.
    function automatic void ref_fmt(input int md, input int ofs, input logic [31:0] mem,
                                    input logic [31:0] rt, output logic [31:0] res,
                                    output logic e);
        logic [7:0] mb[4];
        logic [7:0] rb[4];
        logic [7:0] ob[4];
        int v;
        for (int i = 0; i < 4; i++) begin
            mb[i] = mem[8*i +: 8];
            rb[i] = rt[8*i +: 8];
            ob[i] = 8'h00;
        end
        e = 1'b0;
        res = 32'h0;
        case (md)
            0, 1: begin
                v = int'(mb[ofs]);
                if (md == 0 && v >= 128) v = v - 256;
                res = 32'(v);
            end
            2, 3: begin
                if (ofs % 2 != 0) e = 1'b1;
                else begin
                    v = int'(mb[ofs]) + 256 * int'(mb[ofs+1]);
                    if (md == 2 && v >= 32768) v = v - 65536;
                    res = 32'(v);
                end
            end
            4: begin
                if (ofs != 0) e = 1'b1;
                else res = mem;
            end
            5: begin
                for (int i = 0; i < 4; i++)
                    ob[i] = (i >= 3 - ofs) ? mb[i-(3-ofs)] : rb[i];
                res = {ob[3], ob[2], ob[1], ob[0]};
            end
            6: begin
                for (int i = 0; i < 4; i++)
                    ob[i] = (i + ofs < 4) ? mb[i+ofs] : rb[i];
                res = {ob[3], ob[2], ob[1], ob[0]};
            end
            default: e = 1'b1;
        endcase
        if (e) res = 32'h0;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_res   = 32'h0;
        m_err   = 1'b0;
        m_cnt   = 0;
        m_cnt2  = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, out_valid, m_valid);
        check({tag, ".out_valid2"}, out_valid2, m_valid);
        if (m_valid) begin
            check({tag, ".result"}, result, m_res);
            check({tag, ".err"}, err, m_err);
            check({tag, ".result2"}, result2, m_res);
            check({tag, ".err2"}, err2, m_err);
        end
        check({tag, ".err_count"}, err_count, m_cnt);
        check({tag, ".err_count2"}, err_count2, m_cnt2);
    endtask

    // One clock cycle of stimulus; entered and left just after a falling edge.
    task automatic cyc(input string tag, input logic v, input int md, input int ofs,
                       input logic [31:0] mem, input logic [31:0] rt, input logic rdy);
        logic acc;
        logic [31:0] r;
        logic e;
        in_valid  = v;
        mode      = 3'(md);
        byte_ofs  = 2'(ofs);
        mem_rdata = mem;
        rt_old    = rt;
        out_ready = rdy;
        #1;
        check({tag, ".in_ready"}, in_ready, !m_valid || rdy);
        check({tag, ".in_ready2"}, in_ready2, !m_valid || rdy);
        acc = v && (!m_valid || rdy);
        ref_fmt(md, ofs, mem, rt, r, e);
        @(posedge clk);
        if (acc) begin
            m_valid = 1'b1;
            m_res   = r;
            m_err   = e;
            if (e) begin
                m_cnt  = (m_cnt  < 255) ? m_cnt  + 1 : 255;
                m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
            end
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        in_valid  = 1'b0;
        mode      = 3'd0;
        byte_ofs  = 2'd0;
        mem_rdata = 32'h0;
        rt_old    = 32'h0;
        out_ready = 1'b1;
        reset_n   = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Narrow counter saturates at 3: 1,2,3,3,3.
        for (int i = 0; i < 5; i++) begin
            cyc("sat_lw", 1'b1, 4, 2, 32'hDEADBEEF, 32'h0, 1'b1);
            check("sat_seq", err_count2, (i < 3) ? i + 1 : 3);
        end

        // Directed vectors.
        cyc("lb",    1'b1, 0, 2, 32'h12803456, 32'h0, 1'b1);
        check("lb_val", result, 32'hFFFFFF80);
        cyc("lbu",   1'b1, 1, 2, 32'h12803456, 32'h0, 1'b1);
        check("lbu_val", result, 32'h00000080);
        cyc("lh",    1'b1, 2, 2, 32'h80011234, 32'h0, 1'b1);
        check("lh_val", result, 32'hFFFF8001);
        cyc("lhu",   1'b1, 3, 2, 32'h80011234, 32'h0, 1'b1);
        check("lhu_val", result, 32'h00008001);
        cyc("lh_mis", 1'b1, 2, 1, 32'h80011234, 32'h0, 1'b1);
        check("lh_mis_err", err, 1'b1);
        check("lh_mis_cnt", err_count, 8'd6);
        cyc("lwl1",  1'b1, 5, 1, 32'hAABBCCDD, 32'h11223344, 1'b1);
        check("lwl1_val", result, 32'hCCDD3344);
        cyc("lwr1",  1'b1, 6, 1, 32'hAABBCCDD, 32'h11223344, 1'b1);
        check("lwr1_val", result, 32'h11AABBCC);
        cyc("lwl3",  1'b1, 5, 3, 32'hAABBCCDD, 32'h11223344, 1'b1);
        check("lwl3_val", result, 32'hAABBCCDD);
        cyc("rsvd",  1'b1, 7, 0, 32'hAABBCCDD, 32'h11223344, 1'b1);
        cyc("lw0",   1'b1, 4, 0, 32'h5A5A0F0F, 32'h0, 1'b1);
        cyc("drain", 1'b0, 0, 0, 32'h0, 32'h0, 1'b1);

        // Back-to-back, then 3 cycles of backpressure, then drain.
        for (int i = 0; i < 4; i++)
            cyc("b2b", 1'b1, 4, 0, 32'h1000 + 32'(i), 32'h0, 1'b1);
        for (int i = 0; i < 3; i++)
            cyc("bp", 1'b1, 1, 1, 32'h0000AB00, 32'h0, 1'b0);
        check("bp_held", result, 32'h00001003);
        cyc("bp_rel", 1'b1, 1, 1, 32'h0000AB00, 32'h0, 1'b1);
        check("bp_new", result, 32'h000000AB);
        cyc("drain2", 1'b0, 0, 0, 32'h0, 32'h0, 1'b1);

        // Async reset in the middle of backpressure.
        do_reset();
        cyc("pre_e1", 1'b1, 4, 1, 32'h1, 32'h0, 1'b1);
        cyc("pre_e2", 1'b1, 4, 3, 32'h1, 32'h0, 1'b1);
        cyc("pre_bp", 1'b1, 0, 0, 32'h7F, 32'h0, 1'b0);
        cyc("pre_bp2", 1'b1, 0, 0, 32'h7F, 32'h0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 32'h0);
        check("rst_err", err, 1'b0);
        check("rst_err_count", err_count, 8'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cyc("post_rst", 1'b1, 3, 0, 32'h0000FFFE, 32'h0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cyc("rand", ($urandom_range(0, 9) < 7), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 3)), $urandom, $urandom, ($urandom_range(0, 9) < 7));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_extend_unit.md
LOAD_EXTEND_UNIT -- requirements
Module: load_extend_unit

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, meaning the data word width in bits; legal values are multiples of 8 and at least 16.
REQ-002 SHALL provide parameter ERRCNT_W, default 8, meaning the width of the misalignment error counter.
REQ-003 SHALL derive local constants NB = DATA_W/8 and OFS_W = max(1, clog2(NB)).
REQ-004 SHALL have one clock; reset is asynchronous and active-low. Ports follow.
REQ-005 clk  in  1  single rising-edge clock.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  request present.
REQ-008 in_ready  out  1  unit accepts a request this cycle.
REQ-009 mode  in  3  0=LB, 1=LBU, 2=LH, 3=LHU, 4=LW, 5=LWL, 6=LWR, 7=reserved.
REQ-010 byte_ofs  in  OFS_W  little-endian byte offset of the effective address.
REQ-011 mem_rdata  in  DATA_W  aligned word read from memory.
REQ-012 rt_old  in  DATA_W  current rt value, used for the LWL/LWR merge.
REQ-013 out_valid  out  1  result register holds valid data.
REQ-014 out_ready  in  1  consumer accepts the result.
REQ-015 result  out  DATA_W  formatted load value.
REQ-016 err  out  1  the held result came from a misaligned or reserved request.
REQ-017 err_count  out  ERRCNT_W  saturating count of accepted erroneous requests.

Function
REQ-018 SHALL accept a request on any clk edge where in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
REQ-019 SHALL register the formatted value into result/err on acceptance, so out_valid rises exactly 1 cycle after acceptance.
REQ-020 SHALL hold result, err and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL clear out_valid on out_valid && out_ready with no simultaneous acceptance; on a simultaneous accept, SHALL load the new result with out_valid staying 1 (full throughput, no bubble).
REQ-022 LB/LBU: SHALL select byte b = mem_rdata[8*byte_ofs +: 8]; LB sign-extends b[7] to DATA_W, LBU zero-extends.
REQ-023 LH/LHU: SHALL select the halfword at byte_ofs; LH sign-extends, LHU zero-extends; byte_ofs[0]=1 is misaligned.
REQ-024 LW: SHALL pass mem_rdata unchanged; byte_ofs != 0 is misaligned.
REQ-025 LWL: result = (mem_rdata << 8*(NB-1-byte_ofs)) OR (rt_old AND a mask of the low NB-1-byte_ofs bytes); never misaligned.
REQ-026 LWR: result = (mem_rdata >> 8*byte_ofs) OR (rt_old AND a mask of the high byte_ofs bytes); never misaligned.
REQ-027 Misaligned or mode=7: SHALL set result = 0 and err = 1; otherwise err = 0.
REQ-028 SHALL increment err_count by 1 on each accepted erroneous request and saturate at 2^ERRCNT_W-1 without wrap.
REQ-029 SHALL treat byte_ofs values >= NB (only possible when NB is not a power of 2) as misaligned for every mode.
REQ-030 SHALL leave inputs ignored and state unchanged when in_valid is low or in_ready is low.

Reset
REQ-031 While reset_n = 0, SHALL force out_valid=0, result=0, err=0, err_count=0 immediately, without waiting for clk.
REQ-032 A result pending under backpressure at reset assertion SHALL be discarded; in_ready SHALL be 1 from the first cycle after reset_n rises.
REQ-033 reset_n deassertion SHALL be synchronised externally; no acceptance SHALL occur on the edge coinciding with deassertion if reset_n is still sampled low.

Verification (DATA_W=32)
REQ-034 LB, ofs=2, mem=0x12803456 -> result 0xFFFFFF80, err 0; LBU same -> 0x00000080.
REQ-035 LH, ofs=2, mem=0x80011234 -> 0xFFFF8001; LHU -> 0x00008001; LH ofs=1 -> result 0, err 1, err_count +1.
REQ-036 LWL, ofs=1, mem=0xAABBCCDD, rt=0x11223344 -> 0xCCDD3344; LWR same inputs -> 0x11AABBCC; LWL ofs=3 -> 0xAABBCCDD.
REQ-037 Back-to-back: 4 requests with out_ready held 1 -> 4 results on 4 consecutive cycles; out_ready=0 for 3 cycles -> result held, in_ready=0, nothing lost.
REQ-038 ERRCNT_W=2, 5 accepted LW ofs=2 requests -> err_count sequence 1,2,3,3,3.
REQ-039 reset_n pulsed low mid-backpressure with out_valid=1, err_count=2 -> out_valid, result, err and err_count read 0 before the next clk edge.
